// File: rtl/jtframe_cenwait.sv
// Gates a CPU clock enable while ROM data or a slow device is not ready, and
// repays the suppressed pulses later on the 180-degree cen_b slots.
module jtframe_cenwait #(
    parameter int unsigned DW      = 4,
    parameter int unsigned RECOVER = 1,
    parameter int unsigned MAXWAIT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen_in,
    input  logic          cen_b,
    input  logic          rom_cs,
    input  logic          rom_ok,
    input  logic          dev_busy,
    output logic          cen_out,
    output logic          stall,
    output logic [DW-1:0] debt,
    output logic          timeout
);

    typedef enum logic [1:0] {StIdle, StCheck, StAccess} st_t;

    localparam logic [7:0] MaxWaitC = 8'(MAXWAIT);
    localparam logic       Recover  = (RECOVER != 0);

    st_t        st;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nx;
    logic       rom_wait;

    // rom_ok in the first clk of an access still belongs to the previous access
    always_comb begin
        rom_wait = (st == StCheck) | ((st == StIdle) & rom_cs) | ((st == StAccess) & ~rom_ok);
        stall    = rom_wait | dev_busy;
        wait_nx  = (wait_cnt == 8'hff) ? wait_cnt : wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= StIdle;
            cen_out  <= 1'b0;
            debt     <= '0;
            timeout  <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            case (st)
                StIdle:   if (rom_cs) st <= StCheck;
                StCheck:  st <= rom_cs ? StAccess : StIdle;
                StAccess: if (!rom_cs) st <= StIdle;
                default:  st <= StIdle;
            endcase

            if (cen_in && stall) begin
                cen_out  <= 1'b0;
                wait_cnt <= wait_nx;
                if (debt != '1) debt <= debt + DW'(1);
                if (wait_nx == MaxWaitC) timeout <= 1'b1;
            end else if (cen_in) begin
                cen_out  <= 1'b1;
                wait_cnt <= 8'd0;
            end else if (cen_b && !stall && Recover && debt != '0) begin
                cen_out <= 1'b1;
                debt    <= debt - DW'(1);
            end else begin
                cen_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_cenwait.sv
// Directed bench for jtframe_cenwait: vector table for pass-through and ROM
// qualification, hand sequences for timeout, saturation and async reset.
module tb_jtframe_cenwait;

    logic       clk, rst;
    logic       cen_in, cen_b, rom_cs, rom_ok, dev_busy;
    logic       cen_out, stall, timeout;
    logic [3:0] debt;

    int total = 0;
    int bad   = 0;

    jtframe_cenwait #(.DW(4), .RECOVER(1), .MAXWAIT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen_in   (cen_in),
        .cen_b    (cen_b),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .dev_busy (dev_busy),
        .cen_out  (cen_out),
        .stall    (stall),
        .debt     (debt),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ci, cb, cs, ok, busy;
        logic       exp_stall, exp_cen;
        logic [3:0] exp_debt;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic ci, cb, cs, ok, busy, es, ec, input logic [3:0] ed);
        vec_t t;
        t.ci = ci; t.cb = cb; t.cs = cs; t.ok = ok; t.busy = busy;
        t.exp_stall = es; t.exp_cen = ec; t.exp_debt = ed;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample stall before the rising edge and
    // registered outputs 1 time unit after it.
    task automatic tick(input logic ci, cb, cs, ok, busy, output logic st_s);
        @(negedge clk);
        cen_in = ci; cen_b = cb; rom_cs = cs; rom_ok = ok; dev_busy = busy;
        #1 st_s = stall;
        @(posedge clk);
        #1;
    endtask

    // One cen period: cen_in, gap, cen_b, gap
    task automatic period(input logic busy, inout int pulses);
        logic s;
        for (int ph = 0; ph < 4; ph++) begin
            tick(ph == 0, ph == 2, 1'b0, 1'b0, busy, s);
            if (cen_out) pulses++;
        end
    endtask

    initial begin
        logic s;
        int   n;
        rst = 1'b1; cen_in = 0; cen_b = 0; rom_cs = 0; rom_ok = 0; dev_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset cen_out", cen_out, 0);
        chk("reset debt", debt, 0);
        chk("reset timeout", timeout, 0);
        @(negedge clk) rst = 1'b0;

        // Pass-through
        v(1,0,0,0,0, 0,1,0); v(0,0,0,0,0, 0,0,0); v(0,1,0,0,0, 0,0,0); v(0,0,0,0,0, 0,0,0);
        v(1,0,0,0,0, 0,1,0); v(0,0,0,0,0, 0,0,0); v(0,1,0,0,0, 0,0,0);
        // Stale rom_ok: CHECK state swallows the cen_in, cen_b repays it
        v(0,0,1,1,0, 1,0,0); v(1,0,1,1,0, 1,0,1); v(0,0,1,1,0, 0,0,1); v(0,1,1,1,0, 0,1,0);
        v(0,0,0,1,0, 0,0,0);
        // SDRAM wait across three cen_in pulses, then recovery
        v(1,0,1,0,0, 1,0,1); v(0,0,1,0,0, 1,0,1); v(0,1,1,0,0, 1,0,1); v(0,0,1,0,0, 1,0,1);
        v(1,0,1,0,0, 1,0,2); v(0,0,1,0,0, 1,0,2); v(0,1,1,0,0, 1,0,2); v(0,0,1,0,0, 1,0,2);
        v(1,0,1,0,0, 1,0,3); v(0,0,1,1,0, 0,0,3); v(0,1,1,1,0, 0,1,2); v(0,0,1,1,0, 0,0,2);
        v(1,0,1,1,0, 0,1,2); v(0,0,1,1,0, 0,0,2); v(0,1,1,1,0, 0,1,1); v(0,0,1,1,0, 0,0,1);
        v(1,0,1,1,0, 0,1,1); v(0,0,1,1,0, 0,0,1); v(0,1,1,1,0, 0,1,0); v(0,0,0,1,0, 0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].ci, vecs[i].cb, vecs[i].cs, vecs[i].ok, vecs[i].busy, s);
            chk($sformatf("vec%0d stall", i), s, vecs[i].exp_stall);
            chk($sformatf("vec%0d cen_out", i), cen_out, vecs[i].exp_cen);
            chk($sformatf("vec%0d debt", i), debt, vecs[i].exp_debt);
        end
        chk("table timeout", timeout, 0);

        // Timeout after exactly 8 consecutive suppressed pulses, sticky after release
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, s);
            chk($sformatf("timeout after stall %0d", k), timeout, (k == 8) ? 1 : 0);
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s);
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, s);
            chk($sformatf("cb stalled cen_out %0d", k), cen_out, 0);
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s);
        end
        chk("timeout debt", debt, 8);
        repeat (3) period(1'b0, n);
        chk("timeout sticky", timeout, 1);
        chk("partial repay debt", debt, 5);
        chk("partial repay pulses", n, 6);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst clears timeout", timeout, 0);
        chk("rst clears debt", debt, 0);
        @(negedge clk) rst = 1'b0;

        // Saturation at 15, then exactly 15 repayments
        n = 0;
        repeat (20) period(1'b1, n);
        chk("saturated debt", debt, 15);
        chk("no pulses while stalled", n, 0);
        n = 0;
        repeat (20) period(1'b0, n);
        chk("release pulses (20 + 15)", n, 35);
        chk("debt after release", debt, 0);

        // Async reset mid-recovery
        n = 0;
        repeat (6) period(1'b1, n);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, s);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
        chk("pre-reset cen_out", cen_out, 1);
        chk("pre-reset debt", debt, 5);
        #2 rst = 1'b1;
        #1;
        chk("async rst cen_out", cen_out, 0);
        chk("async rst debt", debt, 0);
        chk("async rst timeout", timeout, 0);
        @(negedge clk) rst = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, s);
        chk("post-reset cen_out", cen_out, 1);
        chk("post-reset debt", debt, 0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
        chk("post-reset no repay", cen_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
